// File: rtl/aes_if_ctrl.sv
// Clocked request controller for the aes_if scan-chain engine: latches one request,
// sequences engine reset/enable, counts trigger edges and captures the ciphertext.
module aes_if_ctrl #(
    parameter int RST_CYCLES     = 1,
    parameter int SETUP_CYCLES   = 1,
    parameter int TRIG_COUNT     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load_i,
    input  logic [127:0] data_i,
    input  logic [255:0] key_i,
    input  logic         pt_sel_i,
    input  logic         key_sel_i,
    input  logic         ct_out_sel_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_o,
    output logic [127:0] data_o,
    output logic [386:0] scan_chain_o,
    output logic         core_rst_n_o,
    output logic         enable_o,
    input  logic         trigger_i,
    input  logic [386:0] ciphertext_i
);

    localparam int CYC_MAX = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam int TCW     = $clog2(TRIG_COUNT + 1);
    localparam int TOW     = $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0]  RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [TCW-1:0] TRIG_TGT   = TCW'(TRIG_COUNT);
    localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RST = 2'd1,
        SETUP    = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cyc_cnt, cyc_cnt_d;
    logic [TCW-1:0] trig_cnt, trig_cnt_d, trig_inc;
    logic [TOW-1:0] to_cnt, to_cnt_d;
    logic           trig_q, trig_rise;

    logic           busy_d, done_d, timeout_d, core_rst_n_d, enable_d;
    logic [127:0]   data_d;
    logic [386:0]   scan_d;

    // Only the low 128 ciphertext bits carry the result.
    logic unused_ct;
    assign unused_ct = ^ciphertext_i[386:128];

    // Edge history runs in every state so a level already high at RUN entry never counts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) trig_q <= 1'b0;
        else        trig_q <= trigger_i;
    end

    assign trig_rise = trigger_i & ~trig_q;
    assign trig_inc  = trig_cnt + TCW'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            trig_cnt     <= '0;
            to_cnt       <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
            core_rst_n_o <= 1'b0;
            enable_o     <= 1'b0;
            data_o       <= '0;
            scan_chain_o <= '0;
        end else begin
            state        <= state_d;
            cyc_cnt      <= cyc_cnt_d;
            trig_cnt     <= trig_cnt_d;
            to_cnt       <= to_cnt_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            timeout_o    <= timeout_d;
            core_rst_n_o <= core_rst_n_d;
            enable_o     <= enable_d;
            data_o       <= data_d;
            scan_chain_o <= scan_d;
        end
    end

    always_comb begin
        state_d      = state;
        cyc_cnt_d    = cyc_cnt;
        trig_cnt_d   = trig_cnt;
        to_cnt_d     = to_cnt;
        busy_d       = busy_o;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        core_rst_n_d = core_rst_n_o;
        enable_d     = enable_o;
        data_d       = data_o;
        scan_d       = scan_chain_o;

        case (state)
            IDLE: begin
                busy_d       = 1'b0;
                enable_d     = 1'b0;
                core_rst_n_d = 1'b1;
                if (load_i) begin
                    scan_d     = {data_i, key_i, pt_sel_i, key_sel_i, ct_out_sel_i};
                    busy_d     = 1'b1;
                    cyc_cnt_d  = '0;
                    trig_cnt_d = '0;
                    to_cnt_d   = '0;
                    state_d    = CORE_RST;
                end
            end
            CORE_RST: begin
                core_rst_n_d = 1'b0;
                if (cyc_cnt == RST_LAST) begin
                    cyc_cnt_d = '0;
                    state_d   = SETUP;
                end else begin
                    cyc_cnt_d = cyc_cnt + CW'(1);
                end
            end
            SETUP: begin
                core_rst_n_d = 1'b1;
                enable_d     = 1'b0;
                if (cyc_cnt == SETUP_LAST) begin
                    cyc_cnt_d  = '0;
                    trig_cnt_d = '0;
                    to_cnt_d   = '0;
                    state_d    = RUN;
                end else begin
                    cyc_cnt_d = cyc_cnt + CW'(1);
                end
            end
            RUN: begin
                core_rst_n_d = 1'b1;
                // Completion wins over a watchdog expiry landing on the same edge.
                if (trig_rise && (trig_inc == TRIG_TGT)) begin
                    data_d   = ciphertext_i[127:0];
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    enable_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    enable_d = 1'b1;
                    if (trig_rise) trig_cnt_d = trig_inc;
                    if (to_cnt == TO_LAST) begin
                        timeout_d = 1'b1;
                        busy_d    = 1'b0;
                        enable_d  = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        to_cnt_d = to_cnt + TOW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_if_ctrl.sv
// Self-checking bench for aes_if_ctrl: directed scenarios plus randomized traffic
// checked against a cycles-since-load reference model for two watchdog settings.
module tb_aes_if_ctrl;

    localparam int R  = 1;
    localparam int S  = 1;
    localparam int TC = 2;
    localparam int T0 = 1024;
    localparam int T1 = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [127:0] data = '0;
    logic [255:0] key = '0;
    logic         pt_sel = 1'b0, key_sel = 1'b0, ct_sel = 1'b0;
    logic         trigger = 1'b0;
    logic [386:0] ct = '0;

    logic         d_busy, d_done, d_tmo, d_crst, d_en;
    logic [127:0] d_data;
    logic [386:0] d_scan;
    logic         t_busy, t_done, t_tmo, t_crst, t_en;
    logic [127:0] t_data;
    logic [386:0] t_scan;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aes_if_ctrl u_dut (
        .CLK(clk), .RST_N(rst_n), .load_i(load), .data_i(data), .key_i(key),
        .pt_sel_i(pt_sel), .key_sel_i(key_sel), .ct_out_sel_i(ct_sel),
        .busy_o(d_busy), .done_o(d_done), .timeout_o(d_tmo), .data_o(d_data),
        .scan_chain_o(d_scan), .core_rst_n_o(d_crst), .enable_o(d_en),
        .trigger_i(trigger), .ciphertext_i(ct)
    );

    aes_if_ctrl #(.TIMEOUT_CYCLES(T1)) u_to (
        .CLK(clk), .RST_N(rst_n), .load_i(load), .data_i(data), .key_i(key),
        .pt_sel_i(pt_sel), .key_sel_i(key_sel), .ct_out_sel_i(ct_sel),
        .busy_o(t_busy), .done_o(t_done), .timeout_o(t_tmo), .data_o(t_data),
        .scan_chain_o(t_scan), .core_rst_n_o(t_crst), .enable_o(t_en),
        .trigger_i(trigger), .ciphertext_i(ct)
    );

    // Reference model: a request is described by k, the index of the current edge
    // counted from the accepting edge; engine reset, setup and run windows follow from k.
    logic         m_prev;
    logic         m_active [2];
    int           m_k [2];
    int           m_cnt [2];
    logic         m_busy [2], m_done [2], m_tmo [2], m_en [2], m_crst [2];
    logic [127:0] m_data [2];
    logic [386:0] m_scan [2];
    wire          m_rise = trigger & ~m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_active[i] <= 1'b0; m_k[i] <= 0; m_cnt[i] <= 0;
                m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_tmo[i] <= 1'b0;
                m_en[i] <= 1'b0; m_crst[i] <= 1'b0;
                m_data[i] <= '0; m_scan[i] <= '0;
            end
        end else begin
            m_prev <= trigger;
            for (int i = 0; i < 2; i++) begin
                m_done[i] <= 1'b0;
                m_tmo[i]  <= 1'b0;
                if (!m_active[i]) begin
                    m_crst[i] <= 1'b1;
                    m_en[i]   <= 1'b0;
                    if (load) begin
                        m_active[i] <= 1'b1; m_k[i] <= 1; m_cnt[i] <= 0; m_busy[i] <= 1'b1;
                        m_scan[i] <= {data, key, pt_sel, key_sel, ct_sel};
                    end
                end else begin
                    m_k[i]    <= m_k[i] + 1;
                    m_crst[i] <= (m_k[i] > R);
                    if (m_k[i] > R + S) begin
                        if (m_rise && (m_cnt[i] + 1 == TC)) begin
                            m_done[i] <= 1'b1; m_data[i] <= ct[127:0];
                            m_busy[i] <= 1'b0; m_en[i] <= 1'b0; m_active[i] <= 1'b0;
                        end else if (m_k[i] == R + S + ((i == 0) ? T0 : T1)) begin
                            m_tmo[i] <= 1'b1;
                            m_busy[i] <= 1'b0; m_en[i] <= 1'b0; m_active[i] <= 1'b0;
                        end else begin
                            m_en[i] <= 1'b1;
                            if (m_rise) m_cnt[i] <= m_cnt[i] + 1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [415:0] rnd416();
        logic [415:0] v;
        for (int w = 0; w < 13; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; load = 1'b0; trigger = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic pulse(input logic [127:0] c);
        trigger = 1'b1; ct[127:0] = c;
        cyc();
        trigger = 1'b0;
    endtask

    task automatic start_req(input logic [127:0] d, input logic [255:0] k);
        data = d; key = k; pt_sel = 1'b1; key_sel = 1'b1; ct_sel = 1'b0;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({d_busy, d_done, d_tmo, d_en, d_crst} !== 5'b0 || d_data !== '0 || d_scan !== '0) begin
            fails++;
            $display("FAIL reset_values: ctl=%b data=%h, required ctl=00000 data=0", {d_busy, d_done, d_tmo, d_en, d_crst}, d_data);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        tests++;
        if (d_crst !== 1'b1 || d_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: core_rst_n=%b busy=%b, required 1/0", d_crst, d_busy);
        end
    endtask

    task automatic test_nominal();
        logic [127:0] d = 128'h00112233445566778899aabbccddeeff;
        logic [127:0] c = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        do_reset();
        start_req(d, '0);
        tests++;
        if (d_busy !== 1'b1 || d_scan !== {d, 256'h0, 3'b110} || d_crst !== 1'b1) begin
            fails++;
            $display("FAIL nominal_latch: busy=%b crst=%b scan=%h, required busy=1 crst=1 scan=%h", d_busy, d_crst, d_scan, {d, 256'h0, 3'b110});
        end
        cyc();
        tests++;
        if (d_crst !== 1'b0 || d_en !== 1'b0) begin
            fails++;
            $display("FAIL nominal_core_rst: crst=%b en=%b, required 0/0", d_crst, d_en);
        end
        cyc();
        tests++;
        if (d_crst !== 1'b1 || d_en !== 1'b0) begin
            fails++;
            $display("FAIL nominal_setup: crst=%b en=%b, required 1/0", d_crst, d_en);
        end
        cyc();
        tests++;
        if (d_en !== 1'b1 || d_busy !== 1'b1) begin
            fails++;
            $display("FAIL nominal_enable: en=%b busy=%b, required 1/1", d_en, d_busy);
        end
        pulse(128'h0);
        tests++;
        if (d_done !== 1'b0 || d_en !== 1'b1) begin
            fails++;
            $display("FAIL nominal_first_trig: done=%b en=%b, required 0/1", d_done, d_en);
        end
        cyc();
        pulse(c);
        tests++;
        if (d_done !== 1'b1 || d_busy !== 1'b0 || d_en !== 1'b0 || d_data !== c || d_tmo !== 1'b0) begin
            fails++;
            $display("FAIL nominal_done: done=%b busy=%b en=%b tmo=%b data=%h, required 1/0/0/0 data=%h", d_done, d_busy, d_en, d_tmo, d_data, c);
        end
        cyc();
        tests++;
        if (d_done !== 1'b0 || d_data !== c) begin
            fails++;
            $display("FAIL nominal_done_width: done=%b data=%h, required 0 data=%h", d_done, d_data, c);
        end
    endtask

    task automatic test_timeout();
        logic [127:0] x = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        int first_idx = -1;
        int tmo_cnt = 0;
        int done_cnt = 0;
        do_reset();
        start_req(128'h1, '0);
        cyc(); cyc();
        pulse(128'h0); cyc(); pulse(x);
        tests++;
        if (t_done !== 1'b1 || t_data !== x) begin
            fails++;
            $display("FAIL timeout_prior: done=%b data=%h, required 1 data=%h", t_done, t_data, x);
        end
        cyc();
        start_req(128'h2, '1);
        for (int idx = 1; idx <= 30; idx++) begin
            cyc();
            if (t_tmo === 1'b1) begin
                tmo_cnt++;
                if (first_idx < 0) first_idx = idx;
            end
            if (t_done === 1'b1) done_cnt++;
            if (idx == 5) begin trigger = 1'b1; ct[127:0] = ~x; end
            if (idx == 6) trigger = 1'b0;
        end
        tests++;
        if (first_idx != R + S + T1 || tmo_cnt != 1) begin
            fails++;
            $display("FAIL timeout_time: edge=%0d pulses=%0d, required edge=%0d pulses=1", first_idx, tmo_cnt, R + S + T1);
        end
        tests++;
        if (done_cnt != 0 || t_data !== x || t_busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state: dones=%0d busy=%b data=%h, required 0/0 data=%h", done_cnt, t_busy, t_data, x);
        end
    endtask

    task automatic test_ignored_load();
        logic [127:0] a = 128'ha5a5_0000_1111_2222_3333_4444_5555_6666;
        logic [127:0] c = 128'h0badc0de_0badc0de_0badc0de_0badc0de;
        logic [386:0] exp_scan;
        int done_cnt = 0;
        do_reset();
        start_req(a, {8{32'h13572468}});
        exp_scan = {a, {8{32'h13572468}}, 3'b110};
        cyc(); cyc(); cyc();
        data = ~a; key = '0; pt_sel = 1'b0; ct_sel = 1'b1; load = 1'b1;
        cyc();
        load = 1'b0;
        tests++;
        if (d_scan !== exp_scan || d_busy !== 1'b1) begin
            fails++;
            $display("FAIL ignored_load_scan: busy=%b scan=%h, required busy=1 scan=%h", d_busy, d_scan, exp_scan);
        end
        pulse(128'h0);
        if (d_done === 1'b1) done_cnt++;
        cyc();
        if (d_done === 1'b1) done_cnt++;
        pulse(c);
        if (d_done === 1'b1) done_cnt++;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (d_done === 1'b1) done_cnt++;
        end
        tests++;
        if (done_cnt != 1 || d_data !== c || d_scan !== exp_scan) begin
            fails++;
            $display("FAIL ignored_load_done: dones=%0d data=%h, required 1 data=%h", done_cnt, d_data, c);
        end
    endtask

    task automatic test_pretrigger();
        logic [127:0] c = 128'h77777777_88888888_99999999_aaaaaaaa;
        do_reset();
        trigger = 1'b1;
        cyc();
        start_req(128'h3, '0);
        for (int i = 0; i < 5; i++) cyc();
        tests++;
        if (d_done !== 1'b0 || d_en !== 1'b1) begin
            fails++;
            $display("FAIL pretrig_held: done=%b en=%b, required 0/1", d_done, d_en);
        end
        trigger = 1'b0;
        cyc();
        pulse(128'h0);
        tests++;
        if (d_done !== 1'b0 || d_busy !== 1'b1) begin
            fails++;
            $display("FAIL pretrig_first: done=%b busy=%b, required 0/1", d_done, d_busy);
        end
        cyc();
        pulse(c);
        tests++;
        if (d_done !== 1'b1 || d_data !== c) begin
            fails++;
            $display("FAIL pretrig_second: done=%b data=%h, required 1 data=%h", d_done, d_data, c);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] c = 128'h12121212_34343434_56565656_78787878;
        int done_cnt = 0;
        do_reset();
        start_req(128'h4, '1);
        cyc(); cyc();
        pulse(128'h0);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({d_busy, d_done, d_tmo, d_en, d_crst} !== 5'b0 || d_data !== '0 || d_scan !== '0) begin
            fails++;
            $display("FAIL midrun_reset: ctl=%b data=%h, required ctl=00000 data=0", {d_busy, d_done, d_tmo, d_en, d_crst}, d_data);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        start_req(128'h5, '0);
        cyc(); cyc();
        pulse(128'h0);
        for (int i = 0; i < 3; i++) begin
            if (d_done === 1'b1) done_cnt++;
            cyc();
        end
        tests++;
        if (done_cnt != 0 || d_busy !== 1'b1) begin
            fails++;
            $display("FAIL midrun_one_trig: dones=%0d busy=%b, required 0/1", done_cnt, d_busy);
        end
        pulse(c);
        tests++;
        if (d_done !== 1'b1 || d_data !== c) begin
            fails++;
            $display("FAIL midrun_second: done=%b data=%h, required 1 data=%h", d_done, d_data, c);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] c1 = 128'hc1c1c1c1_00000000_11111111_c1c1c1c1;
        logic [127:0] c2 = 128'hc2c2c2c2_22222222_33333333_c2c2c2c2;
        logic [127:0] b  = 128'hbbbbbbbb_bbbbbbbb_00000000_00000001;
        logic seen;
        do_reset();
        start_req(128'h6, '0);
        cyc(); cyc();
        pulse(128'h0); cyc(); pulse(c1);
        seen = (d_done === 1'b1);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL b2b_first_done: done=%b, required 1", d_done);
        end
        data = b; key = '1; pt_sel = 1'b0; key_sel = 1'b1; ct_sel = 1'b1; load = 1'b1;
        cyc();
        load = 1'b0;
        tests++;
        if (d_busy !== 1'b1 || d_scan !== {b, {256{1'b1}}, 3'b011}) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b scan=%h, required busy=1 scan=%h", d_busy, d_scan, {b, {256{1'b1}}, 3'b011});
        end
        cyc(); cyc();
        pulse(128'h0); cyc(); trigger = 1'b1; ct[127:0] = c2;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            trigger = 1'b0;
            seen = (d_done === 1'b1);
        end
        tests++;
        if (!seen || d_data !== c2) begin
            fails++;
            $display("FAIL b2b_second: done_seen=%b data=%h, required 1 data=%h", seen, d_data, c2);
        end
    endtask

    task automatic test_random();
        logic [415:0] r;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            tests++;
            if ({d_busy, d_done, d_tmo, d_en, d_crst} !== {m_busy[0], m_done[0], m_tmo[0], m_en[0], m_crst[0]}) begin
                fails++;
                $display("FAIL rand_ctl_dflt @%0d: busy/done/tmo/en/crst=%b, required %b", n,
                         {d_busy, d_done, d_tmo, d_en, d_crst}, {m_busy[0], m_done[0], m_tmo[0], m_en[0], m_crst[0]});
            end
            tests++;
            if ({t_busy, t_done, t_tmo, t_en, t_crst} !== {m_busy[1], m_done[1], m_tmo[1], m_en[1], m_crst[1]}) begin
                fails++;
                $display("FAIL rand_ctl_t16 @%0d: busy/done/tmo/en/crst=%b, required %b", n,
                         {t_busy, t_done, t_tmo, t_en, t_crst}, {m_busy[1], m_done[1], m_tmo[1], m_en[1], m_crst[1]});
            end
            tests++;
            if (d_data !== m_data[0] || t_data !== m_data[1]) begin
                fails++;
                $display("FAIL rand_data @%0d: %h %h, required %h %h", n, d_data, t_data, m_data[0], m_data[1]);
            end
            tests++;
            if (d_scan !== m_scan[0] || t_scan !== m_scan[1]) begin
                fails++;
                $display("FAIL rand_scan @%0d: dflt=%h t16=%h, required %h %h", n, d_scan[386:259], t_scan[386:259], m_scan[0][386:259], m_scan[1][386:259]);
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            load = ($urandom_range(0, 7) == 0);
            r = rnd416();
            data = r[127:0];
            key = r[383:128];
            {pt_sel, key_sel, ct_sel} = r[386:384];
            ct = rnd416()[386:0];
            if ($urandom_range(0, 2) == 0) trigger = ~trigger;
            cyc();
        end
        rst_n = 1'b1;
        load = 1'b0;
    endtask

    initial begin
        cyc();
        test_reset();
        test_nominal();
        test_timeout();
        test_ignored_load();
        test_pretrigger();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
